// File: rtl/updn_cnt_sequencer_if.sv
// Command/response channel between a requester and the up/down counter sequencer.
interface updn_cnt_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/updn_cnt_sequencer.sv
// Sequences LOAD/UP/DOWN/HOLD commands onto an up/down counter's control pins,
// then samples the counter and reports its value against the modelled result.
module updn_cnt_sequencer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  updn_cnt_sequencer_if.slave        bus,
  output logic                       ld_cnt,
  output logic                       updn_cnt,
  output logic                       count_enb,
  output logic [WIDTH-1:0]           data_out,
  input  logic [WIDTH-1:0]           cnt_q
);
  // state  | meaning
  // IDLE   | ready for a command, counter idle-driven
  // RUN    | driving load / count / hold cycles
  // SETTLE | counter holds final value, capture and check it
  // RESP   | response presented until consumed
  typedef enum logic [1:0] {IDLE, RUN, SETTLE, RESP} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic [LEN_W-1:0] len_cnt;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             accept;
  logic             run_done;

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign run_done      = (len_cnt == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_cnt    = 1'b1;
    updn_cnt  = 1'b1;
    count_enb = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_t'(bus.cmd_op) == OP_LOAD || bus.cmd_len != '0) state_nxt = RUN;
          else                                                  state_nxt = SETTLE;
        end
      end
      RUN: begin
        case (op)
          OP_LOAD: ld_cnt = 1'b0;
          OP_UP:   count_enb = 1'b1;
          OP_DOWN: begin
            count_enb = 1'b1;
            updn_cnt  = 1'b0;
          end
          default: ;
        endcase
        if (run_done) state_nxt = SETTLE;
      end
      SETTLE: state_nxt = RESP;
      RESP:   if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Length timer counts down to 1; LOAD always runs for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      op         <= OP_LOAD;
      len_cnt    <= '0;
      expected   <= '0;
      data_out   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op      <= op_t'(bus.cmd_op);
        len_cnt <= (op_t'(bus.cmd_op) == OP_LOAD) ? LEN_W'(1) : bus.cmd_len;
        case (op_t'(bus.cmd_op))
          OP_LOAD: begin
            expected <= bus.cmd_data;
            data_out <= bus.cmd_data;
          end
          OP_UP:   expected <= cnt_q + WIDTH'(bus.cmd_len);
          OP_DOWN: expected <= cnt_q - WIDTH'(bus.cmd_len);
          default: expected <= cnt_q;
        endcase
      end else if (state == RUN && !run_done) begin
        len_cnt <= len_cnt - LEN_W'(1);
      end
      if (state == SETTLE) begin
        rsp_data_q <= cnt_q;
        rsp_err_q  <= (cnt_q != expected);
      end
    end
  end
endmodule

// File: tb/tb_updn_cnt_sequencer.sv
// Directed and randomized bench for updn_cnt_sequencer with an attached counter
// and an arithmetic reference of the counter value and response timing.
module tb_updn_cnt_sequencer;
  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_cnt, updn_cnt, count_enb;
  logic [WIDTH-1:0]  data_out;
  logic [WIDTH-1:0]  cnt_q = '0;
  logic              stuck = 1'b0;
  logic [WIDTH-1:0]  mdl = '0;
  logic [WIDTH-1:0]  last_ld = '0;
  int                total = 0;
  int                bad = 0;

  updn_cnt_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  updn_cnt_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .data_out  (data_out),
    .cnt_q     (cnt_q)
  );

  always #5 clk = ~clk;

  // Attached counter; "stuck" freezes counting but still allows loads.
  always @(posedge clk) begin
    if (!ld_cnt)                  cnt_q <= data_out;
    else if (count_enb && !stuck) cnt_q <= updn_cnt ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input logic [7:0] len,
                        input int stall);
    logic [15:0] base, ideal, exp_data;
    int n_ld, n_en, n_dn, n_rdy, lat, wait_n, exp_lat;
    logic ld_data_ok;
    wait_n = 0;
    while (!bus.cmd_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("cmd_ready_before", bus.cmd_ready, 1);
    check("cnt_before", cnt_q, mdl);
    base = mdl;
    case (op)
      2'd0:    ideal = d;
      2'd1:    ideal = base + 16'(len);
      2'd2:    ideal = base - 16'(len);
      default: ideal = base;
    endcase
    exp_data = (stuck && (op == 2'd1 || op == 2'd2)) ? base : ideal;
    exp_lat  = (op == 2'd0) ? 3 : int'(len) + 2;
    if (op == 2'd0) last_ld = d;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_len   = len;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = 16'($urandom);
    bus.cmd_len   = 8'($urandom);
    n_ld = 0; n_en = 0; n_dn = 0; n_rdy = 0; lat = 1; ld_data_ok = 1'b1;
    while (!bus.rsp_valid && lat < 400) begin
      if (!ld_cnt) begin
        n_ld++;
        if (data_out !== d) ld_data_ok = 1'b0;
      end
      if (count_enb) begin
        n_en++;
        if (!updn_cnt) n_dn++;
      end
      if (bus.cmd_ready) n_rdy++;
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", lat, exp_lat);
    check("ld_cycles", n_ld, (op == 2'd0) ? 1 : 0);
    check("ld_data", ld_data_ok, 1);
    check("en_cycles", n_en, (op == 2'd1 || op == 2'd2) ? int'(len) : 0);
    check("dn_cycles", n_dn, (op == 2'd2) ? int'(len) : 0);
    check("ready_busy", n_rdy, 0);
    check("rsp_data", bus.rsp_data, exp_data);
    check("rsp_err", bus.rsp_err, (exp_data != ideal) ? 1 : 0);
    check("idle_drive", {ld_cnt, updn_cnt, count_enb}, 3'b110);
    check("data_out_hold", data_out, last_ld);
    for (int i = 0; i < stall; i++) begin
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_data", {bus.rsp_err, bus.rsp_data}, {(exp_data != ideal), exp_data});
      check("stall_ready", {bus.cmd_ready, count_enb}, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after", bus.rsp_valid, 0);
    check("cmd_ready_after", bus.cmd_ready, 1);
    mdl = exp_data;
  endtask

  initial begin
    logic [15:0] base;
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    bus.rsp_ready = 1'b0;

    // reset
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_in_rst", bus.cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ctl", {ld_cnt, updn_cnt, count_enb}, 3'b110);
    check("rst_data_out", data_out, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
    check("rst_ready", bus.cmd_ready, 1);

    // directed
    do_cmd(2'd0, 16'h1234, 8'd0, 0);
    do_cmd(2'd0, 16'hFFFE, 8'd0, 0);
    do_cmd(2'd1, 16'h0000, 8'd3, 1);
    do_cmd(2'd0, 16'h0001, 8'd0, 0);
    do_cmd(2'd2, 16'h0000, 8'd2, 0);
    do_cmd(2'd1, 16'h0000, 8'd0, 0);
    do_cmd(2'd3, 16'h0000, 8'd5, 4);
    do_cmd(2'd2, 16'h0000, 8'd0, 2);
    do_cmd(2'd3, 16'h0000, 8'd0, 0);
    stuck = 1'b1;
    do_cmd(2'd1, 16'h0000, 8'd4, 0);
    do_cmd(2'd0, 16'h00AA, 8'd0, 0);
    stuck = 1'b0;

    // randomized
    for (int k = 0; k < 30; k++) begin
      stuck = ($urandom_range(0, 5) == 0);
      do_cmd(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom_range(0, 12)),
             int'($urandom_range(0, 3)));
    end
    stuck = 1'b0;

    // reset during RUN of UP len=10
    base = mdl;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    bus.cmd_len   = 8'd10;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_en_before", count_enb, 1);
      if (i < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_ctl", {ld_cnt, updn_cnt, count_enb}, 3'b110);
    check("abort_outs", {bus.rsp_valid, bus.cmd_ready, data_out}, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_cnt", cnt_q, base + 16'd3);
    mdl = base + 16'd3;
    last_ld = '0;
    do_cmd(2'd2, 16'h0000, 8'd7, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
